rr_priority_arbiter: RTL and testbench

//  Parametrised round-robin arbiter: N requesters, one shared resource. It generalises the
//  4-bit lowest-set-bit isolate/mask utilities to N bits and adds state:
//  - a rotating priority mask
//  - a registered one-hot grant, held until the consumer acks.

---
 rtl/rr_priority_arbiter.sv | 126 ++++++++++++
 tb/tb_rr_priority_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_priority_arbiter.sv
// rtl/rr_priority_arbiter.sv - round-robin arbiter with rotating mask and registered one-hot grant
module rr_priority_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             ack,
    output logic [N-1:0]     grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [N-1:0] grant_nxt;
    logic [N-1:0] mask;
    logic [N-1:0] mask_nxt;
    logic [N-1:0] req_rest;

    // Isolate the lowest set bit; zero stays zero.
    function automatic logic [N-1:0] lowest_bit(input logic [N-1:0] v);
        logic [N-1:0] r;
        logic         found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (v[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Prefer requesters the mask still favours; otherwise fall back to the lowest requester.
    function automatic logic [N-1:0] arbitrate(input logic [N-1:0] r, input logic [N-1:0] m);
        logic [N-1:0] masked;
        masked = r & m;
        return (masked != '0) ? lowest_bit(masked) : lowest_bit(r);
    endfunction

    // Bits strictly above the one-hot grant; granting the top bit wraps to all-ones.
    function automatic logic [N-1:0] mask_above(input logic [N-1:0] g);
        logic [N-1:0] m;
        logic         seen;
        m    = '0;
        seen = 1'b0;
        for (int i = 0; i < N; i++) begin
            m[i] = seen;
            if (g[i]) begin
                seen = 1'b1;
            end
        end
        return (m == '0) ? '1 : m;
    endfunction

    // Binary index of a one-hot vector; zero when idle.
    function automatic logic [IDX_W-1:0] encode(input logic [N-1:0] g);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (g[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // State, grant and mask registers; async reset drops the grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= '0;
            mask  <= '1;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            mask  <= mask_nxt;
        end
    end

    // Next-state logic: issue, hold, advance on ack (back-to-back), or abandon.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        mask_nxt  = mask;
        req_rest  = req & ~grant;
        case (state)
            IDLE: begin
                if (req != '0) begin
                    grant_nxt = arbitrate(req, mask);
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (ack) begin
                    mask_nxt = mask_above(grant);
                    if (req_rest != '0) begin
                        grant_nxt = arbitrate(req_rest, mask_above(grant));
                    end else begin
                        grant_nxt = '0;
                        state_nxt = IDLE;
                    end
                end else if ((req & grant) == '0) begin
                    grant_nxt = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                grant_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign grant_valid = (grant != '0);
    assign grant_idx   = encode(grant);

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// tb/tb_rr_priority_arbiter.sv - self-checking bench for rr_priority_arbiter
module tb_rr_priority_arbiter;

    localparam int N     = 4;
    localparam int IDX_W = 2;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req;
    logic             ack;
    logic [N-1:0]     grant;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;

    int total_cnt;
    int pass_cnt;

    // Reference model: granted index (-1 when idle) and first index the mask favours.
    int m_gnt;
    int m_start;

    rr_priority_arbiter #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .ack         (ack),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        ack   = 1'b0;
        cyc();
        rst_n = 1'b1;
        m_gnt   = -1;
        m_start = 0;
    endtask

    // Search upward from the favoured index, then wrap to the bottom.
    function automatic int model_pick(input logic [N-1:0] r, input int start);
        for (int i = start; i < N; i++) if (r[i]) return i;
        for (int i = 0; i < N; i++) if (r[i]) return i;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] v;
        v = '0;
        if (k >= 0) v[k] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        ack   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            total_cnt++;
            if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'd0)
                $display("FAIL reset cyc%0d: grant=%b valid=%b idx=%0d, want 0000/0/0", i, grant, grant_valid, grant_idx);
            else pass_cnt++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_seq [5];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        req = 4'b1111;
        ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            total_cnt++;
            if (grant !== exp_seq[i])
                $display("FAIL round_robin step%0d: grant=%b, want %b", i, grant, exp_seq[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_mask_wrap();
        logic [N-1:0]     exp_g [4];
        logic [IDX_W-1:0] exp_i [4];
        exp_g = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
        exp_i = '{2'd0, 2'd2, 2'd0, 2'd2};
        do_reset();
        req = 4'b0101;
        ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            total_cnt++;
            if (grant !== exp_g[i] || grant_idx !== exp_i[i] || grant_valid !== 1'b1)
                $display("FAIL mask_wrap step%0d: grant=%b idx=%0d valid=%b, want %b/%0d/1",
                         i, grant, grant_idx, grant_valid, exp_g[i], exp_i[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_hold();
        do_reset();
        req = 4'b0011;
        ack = 1'b0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            cyc();
            total_cnt++;
            if (grant !== 4'b0001)
                $display("FAIL hold cyc%0d: grant=%b, want 0001", i, grant);
            else pass_cnt++;
        end
        ack = 1'b1;
        cyc();
        total_cnt++;
        if (grant !== 4'b0010)
            $display("FAIL hold_release: grant=%b, want 0010", grant);
        else pass_cnt++;
    endtask

    task automatic test_abandon();
        do_reset();
        req = 4'b0100;
        ack = 1'b0;
        cyc();
        total_cnt++;
        if (grant !== 4'b0100) $display("FAIL abandon_setup: grant=%b, want 0100", grant);
        else pass_cnt++;
        req = 4'b0001;
        cyc();
        total_cnt++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0)
            $display("FAIL abandon_drop: grant=%b valid=%b, want 0000/0", grant, grant_valid);
        else pass_cnt++;
        cyc();
        total_cnt++;
        if (grant !== 4'b0001 || grant_idx !== 2'd0)
            $display("FAIL abandon_resume: grant=%b idx=%0d, want 0001/0", grant, grant_idx);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b1000;
        ack = 1'b0;
        cyc();
        total_cnt++;
        if (grant !== 4'b1000 || grant_idx !== 2'd3)
            $display("FAIL async_setup: grant=%b idx=%0d, want 1000/3", grant, grant_idx);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'd0)
            $display("FAIL async_drop: grant=%b valid=%b idx=%0d, want 0000/0/0", grant, grant_valid, grant_idx);
        else pass_cnt++;
        req = 4'b1001;
        #1;
        rst_n = 1'b1;
        cyc();
        total_cnt++;
        if (grant !== 4'b0001)
            $display("FAIL async_first: grant=%b, want 0001", grant);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [N-1:0] rem;
        int           nxt_gnt;
        int           nxt_start;
        logic [N-1:0] exp_grant;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req = N'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) req = '0;
            ack = ($urandom_range(0, 2) != 0);
            nxt_gnt   = m_gnt;
            nxt_start = m_start;
            if (m_gnt < 0) begin
                nxt_gnt = model_pick(req, m_start);
            end else if (ack) begin
                nxt_start = (m_gnt + 1) % N;
                rem       = req & ~onehot(m_gnt);
                nxt_gnt   = model_pick(rem, nxt_start);
            end else if (!req[m_gnt]) begin
                nxt_gnt = -1;
            end
            cyc();
            m_gnt     = nxt_gnt;
            m_start   = nxt_start;
            exp_grant = onehot(m_gnt);
            total_cnt++;
            if (grant !== exp_grant || grant_valid !== (m_gnt >= 0) ||
                grant_idx !== IDX_W'((m_gnt < 0) ? 0 : m_gnt))
                $display("FAIL random cyc%0d: grant=%b valid=%b idx=%0d, want %b/%0d/%0d",
                         i, grant, grant_valid, grant_idx, exp_grant, (m_gnt >= 0), (m_gnt < 0) ? 0 : m_gnt);
            else pass_cnt++;
        end
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        rst_n     = 1'b0;
        req       = '0;
        ack       = 1'b0;
        m_gnt     = -1;
        m_start   = 0;
        #1;
        test_reset();
        test_round_robin();
        test_mask_wrap();
        test_hold();
        test_abandon();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
